bus4_capture_bank: RTL and testbench

Receive-side counterpart of the 4-bit shared-bus driver. A group of N sources drives one 4-bit bus through tri-state buffers, with active-low per-source enables. This block takes the bus back into N independent 4-bit holding registers. Each register has a valid flag and a consumer acknowledge, and the block keeps sticky error flags for bus contention and overwrite.

---
 rtl/bus4_capture_bank.sv | 79 +++++++
 tb/tb_bus4_capture_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bus4_capture_bank.sv
// Captures a shared 4-bit tri-state bus into N slot registers, each with a valid/ack handshake and sticky error flags.
// Latency: 1 cycle write and ack. Backpressure: none; overwrites of unacked slots are flagged, not stalled.
module bus4_capture_bank #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   g,
    input  logic [3:0]     d,
    input  logic           we,
    input  logic [N-1:0]   ack,
    input  logic           err_clr,
    output logic [4*N-1:0] q,
    output logic [N-1:0]   valid,
    output logic           cont_err,
    output logic           ovf_err,
    output logic           busy
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]   sel;
    logic           any_sel;
    logic           multi_sel;
    logic           accept;
    logic           contend;
    logic           ovf_set;

    logic [4*N-1:0] q_q, q_d;
    logic [N-1:0]   valid_q, valid_d;
    logic           cont_q, cont_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;

    // Clearing the lowest set bit leaves something behind exactly when two or more selects are low.
    assign sel       = ~g;
    assign any_sel   = (sel != '0);
    assign multi_sel = ((sel & (sel - ONE)) != '0);
    assign accept    = we && any_sel && !multi_sel;
    assign contend   = we && multi_sel;
    assign ovf_set   = accept && ((sel & valid_q & ~ack) != '0);

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q & ~ack;
        for (int i = 0; i < N; i++) begin
            if (accept && sel[i]) begin
                q_d[4*i +: 4] = d;
                valid_d[i]    = 1'b1;
            end
        end
        cont_d = contend | (cont_q & ~err_clr);
        ovf_d  = ovf_set | (ovf_q & ~err_clr);
        busy_d = accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= '0;
            cont_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            cont_q  <= cont_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign q        = q_q;
    assign valid    = valid_q;
    assign cont_err = cont_q;
    assign ovf_err  = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bus4_capture_bank.sv
// Directed bench for bus4_capture_bank with N=8 and hand-computed expectations.
module tb_bus4_capture_bank;

    logic        clk;
    logic        rst_n;
    logic [7:0]  g;
    logic [3:0]  d;
    logic        we;
    logic [7:0]  ack;
    logic        err_clr;
    logic [31:0] q;
    logic [7:0]  valid;
    logic        cont_err;
    logic        ovf_err;
    logic        busy;

    int tests_run;
    int tests_failed;

    bus4_capture_bank #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .g        (g),
        .d        (d),
        .we       (we),
        .ack      (ack),
        .err_clr  (err_clr),
        .q        (q),
        .valid    (valid),
        .cont_err (cont_err),
        .ovf_err  (ovf_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        g       = 8'hFF;
        d       = 4'h0;
        we      = 1'b0;
        ack     = 8'h00;
        err_clr = 1'b0;
    endtask

    task automatic wr(input int slot, input logic [3:0] val);
        logic [7:0] oh;
        oh = 8'h01 << slot;
        g  = ~oh;
        d  = val;
        we = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();
        step();
        step();
        chk("reset_q", q, 32'h0);
        chk("reset_valid", valid, 8'h00);
        chk("reset_flags", {cont_err, ovf_err, busy}, 3'b000);
        rst_n = 1'b1;

        // Single write and ack
        g = 8'hFB; d = 4'hA; we = 1'b1;
        step();
        idle_inputs();
        chk("wr_q", q[11:8], 4'hA);
        chk("wr_valid", valid, 8'h04);
        chk("wr_busy", busy, 1'b1);
        step();
        chk("busy_pulse", busy, 1'b0);
        ack = 8'h04;
        step();
        idle_inputs();
        chk("ack_valid", valid, 8'h00);
        chk("ack_q_kept", q[11:8], 4'hA);

        // Overwrite without ack
        wr(5, 4'h3);
        step();
        wr(5, 4'h7);
        step();
        idle_inputs();
        chk("ovf_q", q[23:20], 4'h7);
        chk("ovf_set", ovf_err, 1'b1);
        chk("ovf_valid", valid, 8'h20);
        err_clr = 1'b1; ack = 8'h20;
        step();
        idle_inputs();
        chk("ovf_clr", ovf_err, 1'b0);
        chk("ovf_clr_valid", valid, 8'h00);

        // Overwrite with ack on the same slot: write wins, no overflow
        wr(5, 4'h3);
        step();
        wr(5, 4'h7); ack = 8'h20;
        step();
        idle_inputs();
        chk("wack_ovf", ovf_err, 1'b0);
        chk("wack_valid", valid, 8'h20);
        chk("wack_q", q[23:20], 4'h7);

        // Contention
        g = 8'hF6; d = 4'hF; we = 1'b1;
        step();
        idle_inputs();
        chk("cont_q", q, 32'h0070_0A00);
        chk("cont_valid", valid, 8'h20);
        chk("cont_set", cont_err, 1'b1);
        chk("cont_busy", busy, 1'b0);
        err_clr = 1'b1;
        step();
        idle_inputs();
        chk("cont_clr", cont_err, 1'b0);
        g = 8'hF6; d = 4'hF; we = 1'b1; err_clr = 1'b1;
        step();
        idle_inputs();
        chk("cont_set_wins", cont_err, 1'b1);
        err_clr = 1'b1;
        step();
        idle_inputs();

        // Idle with we=1 and no select
        g = 8'hFF; we = 1'b1; d = 4'h5;
        step();
        idle_inputs();
        chk("idle_q", q, 32'h0070_0A00);
        chk("idle_state", {valid, cont_err, ovf_err, busy}, {8'h20, 3'b000});

        // Broadcast to all slots on consecutive cycles
        ack = 8'hFF;
        step();
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            wr(i, 4'(i + 1));
            step();
        end
        idle_inputs();
        chk("bcast_q", q, 32'h8765_4321);
        chk("bcast_valid", valid, 8'hFF);
        chk("bcast_ovf", ovf_err, 1'b0);
        chk("bcast_busy", busy, 1'b1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_q", q, 32'h0);
        chk("areset_valid", valid, 8'h00);
        chk("areset_flags", {cont_err, ovf_err, busy}, 3'b000);
        #1;
        rst_n = 1'b1;
        step();

        // Reset asserted across an accepted write
        wr(0, 4'h9);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        step();
        chk("rstwr_q", q[3:0], 4'h0);
        chk("rstwr_valid", valid, 8'h00);

        // First edge after release is a normal write
        wr(0, 4'h9);
        step();
        idle_inputs();
        chk("post_rst_q", q[3:0], 4'h9);
        chk("post_rst_valid", valid, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
